fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. Holds the program counter, drives the instruction-memory address, and registers the fetched word into the decode stage. The decode stage feeds `op_d` straight into the main control decoder. Also applies stall and branch/jump redirect requests returned from decode.

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register of the
// pipelined MIPS core. Holds the PC, drives the instruction-memory address,
// registers the fetched word into decode and applies stall/redirect requests.
//
// Build option:
//   FETCH_DELAY_SLOT_EN  defined   -> architectural branch delay slot; a
//                                     redirect still loads the fetched word
//                                     into IF/ID (zero-bubble redirect).
//                        undefined -> a redirect flushes IF/ID to NOP_WORD
//                                     with valid_d=0 (one-bubble redirect).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_f,
  input  logic        pcsrc_d,
  input  logic [31:0] pcbranch_d,
  input  logic        jump_d,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic [5:0]  op_d,
  output logic [5:0]  funct_d
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2
  } flow_e;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pcplus4;
  logic        r_valid;

  logic [31:0] w_pcplus4_f;
  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;
  logic [31:0] w_redirect_pc;
  logic        w_redirect;
  flow_e       w_flow;

  // Sequential PC increment wraps naturally at 32 bits.
  assign w_pcplus4_f     = r_pc + 32'd4;
  // Jump target is formed from the J instruction currently held in IF/ID.
  assign w_jump_target   = {r_pcplus4[31:28], r_instr[25:0], 2'b00};
  // Masking (rather than slicing) keeps every bit of the branch input consumed.
  assign w_branch_target = pcbranch_d & 32'hFFFF_FFFC;
  assign w_redirect      = jump_d | pcsrc_d;

  // Flow decision for this cycle: stall beats redirect, redirect beats run.
  always_comb begin
    w_flow = RUN;
    if (stall_f) begin
      w_flow = HOLD;
    end else if (w_redirect) begin
      w_flow = REDIRECT;
    end
  end

  // Redirect target select: jump wins over a simultaneous branch.
  always_comb begin
    w_redirect_pc = w_branch_target;
    if (jump_d) begin
      w_redirect_pc = w_jump_target;
    end
  end

  // PC and IF/ID register update; reset overrides any stall or redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= NOP_WORD;
      r_pcplus4 <= '0;
      r_valid   <= 1'b0;
    end else begin
      unique case (w_flow)
        HOLD: begin
          r_pc      <= r_pc;
          r_instr   <= r_instr;
          r_pcplus4 <= r_pcplus4;
          r_valid   <= r_valid;
        end
        REDIRECT: begin
          r_pc <= w_redirect_pc;
`ifdef FETCH_DELAY_SLOT_EN
          r_instr   <= imem_rdata;
          r_pcplus4 <= w_pcplus4_f;
          r_valid   <= 1'b1;
`else
          r_instr   <= NOP_WORD;
          r_pcplus4 <= '0;
          r_valid   <= 1'b0;
`endif
        end
        default: begin
          r_pc      <= w_pcplus4_f;
          r_instr   <= imem_rdata;
          r_pcplus4 <= w_pcplus4_f;
          r_valid   <= 1'b1;
        end
      endcase
    end
  end

  assign pc_f      = r_pc;
  assign imem_addr = r_pc;
  assign instr_d   = r_instr;
  assign pcplus4_d = r_pcplus4;
  assign valid_d   = r_valid;
  assign op_d      = r_instr[31:26];
  assign funct_d   = r_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed test-plan sequence followed by
// randomized stall/branch/jump/reset traffic, checked by a scoreboard fed
// from a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] P_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] P_NOP_WORD = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_f;
  logic        pcsrc_d;
  logic [31:0] pcbranch_d;
  logic        jump_d;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic [5:0]  op_d;
  logic [5:0]  funct_d;

  fetch_stage #(
    .RESET_PC(P_RESET_PC),
    .NOP_WORD(P_NOP_WORD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .stall_f   (stall_f),
    .pcsrc_d   (pcsrc_d),
    .pcbranch_d(pcbranch_d),
    .jump_d    (jump_d),
    .pc_f      (pc_f),
    .instr_d   (instr_d),
    .pcplus4_d (pcplus4_d),
    .valid_d   (valid_d),
    .op_d      (op_d),
    .funct_d   (funct_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: sequential (imem[i]=i+1) or hashed words,
  // with one optional overridden location for the jump scenario.
  logic        seq_mode;
  logic        ovr_en;
  logic [31:0] ovr_addr;
  logic [31:0] ovr_data;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    if (seq_mode) return (a / 4) + 1;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
  } exp_t;

  exp_t expq[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: what the fetch stage should hold architecturally.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcp4;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, push the expectation.
  task automatic step(input logic rst, input logic st, input logic br,
                      input logic [31:0] tgt, input logic jp);
    exp_t        e;
    logic [31:0] fetched;
    logic [31:0] seq;
    @(negedge clk);
    reset      = rst;
    stall_f    = st;
    pcsrc_d    = br;
    pcbranch_d = tgt;
    jump_d     = jp;
    fetched = imem_word(m_pc);
    seq     = m_pc + 4;
    if (rst) begin
      m_pc = P_RESET_PC; m_instr = P_NOP_WORD; m_pcp4 = 0; m_valid = 0;
    end else if (st) begin
      // everything held
    end else if (jp || br) begin
      logic [31:0] target;
      if (jp) target = (m_pcp4 & 32'hF000_0000) | ((m_instr % (1 << 26)) * 4);
      else    target = tgt - (tgt % 4);
`ifdef FETCH_DELAY_SLOT_EN
      m_instr = fetched; m_pcp4 = seq; m_valid = 1;
`else
      m_instr = P_NOP_WORD; m_pcp4 = 0; m_valid = 0;
`endif
      m_pc = target;
    end else begin
      m_instr = fetched; m_pcp4 = seq; m_valid = 1; m_pc = seq;
    end
    e.pc = m_pc; e.instr = m_instr; e.pcp4 = m_pcp4; e.valid = m_valid;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_step();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: after every active edge, compare DUT state against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("sb_pc_f",      pc_f,                e.pc);
      chk("sb_imem_addr", imem_addr,           e.pc);
      chk("sb_instr_d",   instr_d,             e.instr);
      chk("sb_pcplus4_d", pcplus4_d,           e.pcp4);
      chk("sb_valid_d",   {31'b0, valid_d},    {31'b0, e.valid});
      chk("sb_op_d",      {26'b0, op_d},       e.instr >> 26);
      chk("sb_funct_d",   {26'b0, funct_d},    e.instr % 64);
    end
  end

  initial begin
    reset = 1'b1; stall_f = 1'b0; pcsrc_d = 1'b0; pcbranch_d = '0; jump_d = 1'b0;
    seq_mode = 1'b1; ovr_en = 1'b0; ovr_addr = '0; ovr_data = '0;
    m_pc = '0; m_instr = '0; m_pcp4 = '0; m_valid = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset_pc", pc_f, 32'h0);
    chk("reset_valid", {31'b0, valid_d}, 32'h0);

    // Free run with imem[i]=i+1
    run_step();
    chk("run1_instr", instr_d, 32'd1);
    chk("run1_pcp4", pcplus4_d, 32'd4);
    chk("run1_valid", {31'b0, valid_d}, 32'd1);
    run_step();
    chk("run2_instr", instr_d, 32'd2);
    chk("run2_pcp4", pcplus4_d, 32'd8);
    run_step();
    run_step();
    chk("pre_stall_pc", pc_f, 32'h10);

    // Three-cycle stall at pc 0x10
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("stall_pc", pc_f, 32'h10);
      chk("stall_instr", instr_d, 32'd4);
    end
    run_step();
    chk("post_stall_pc", pc_f, 32'h14);
    chk("post_stall_instr", instr_d, 32'd5);
    run_step();
    run_step();
    run_step();
    chk("pre_branch_pc", pc_f, 32'h20);

    // Branch with misaligned target
    step(1'b0, 1'b0, 1'b1, 32'h43, 1'b0);
    chk("branch_pc", pc_f, 32'h40);
`ifdef FETCH_DELAY_SLOT_EN
    chk("branch_slot_instr", instr_d, 32'd9);
    chk("branch_slot_valid", {31'b0, valid_d}, 32'd1);
`else
    chk("branch_bubble_instr", instr_d, 32'd0);
    chk("branch_bubble_valid", {31'b0, valid_d}, 32'd0);
`endif
    run_step();

    // Jump: place J 0x100 at 0x1000_0004, branch there, then jump (with pcsrc too)
    ovr_en = 1'b1; ovr_addr = 32'h1000_0004; ovr_data = 32'h0800_0100;
    step(1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b0);
    run_step();
    chk("jump_setup_instr", instr_d, 32'h0800_0100);
    chk("jump_setup_pcp4", pcplus4_d, 32'h1000_0008);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b1);
    chk("jump_pc", pc_f, 32'h1000_0400);
    ovr_en = 1'b0;
    run_step();

    // Stall together with a branch: branch ignored
    step(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    chk("stall_br_pc", pc_f, 32'h1000_0404);
    run_step();

    // Wrap at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("wrap_pre_pc", pc_f, 32'hFFFF_FFFC);
    run_step();
    chk("wrap_pc", pc_f, 32'h0);
    chk("wrap_pcp4", pcplus4_d, 32'h0);

    // Reset asserted during a stall
    run_step();
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b1);
    chk("reset_in_stall_pc", pc_f, P_RESET_PC);
    chk("reset_in_stall_valid", {31'b0, valid_d}, 32'd0);

    // Randomized traffic over hashed memory
    seq_mode = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      logic rr, ss, bb, jj;
      rr = ($urandom_range(0, 99) < 1);
      ss = ($urandom_range(0, 99) < 25);
      bb = ($urandom_range(0, 99) < 12);
      jj = ($urandom_range(0, 99) < 8);
      step(rr, ss, bb, $urandom, jj);
    end
    run_step();

    // Drain scoreboard with a bounded wait
    begin
      int budget;
      budget = 10;
      while (expq.size() > 0 && budget > 0) begin
        @(posedge clk);
        #2;
        budget--;
      end
      checks++;
      if (expq.size() > 0) begin
        errors++;
        $display("FAIL drain: got %0d pending expected 0", expq.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
